exhaustive_sweep_checker: RTL and testbench
===========================================

Name: exhaustive_sweep_checker

Overview:
Self-checking exhaustive stimulus engine for N-input single-output combinational blocks. Replaces the hand-written pattern lists used in per-function benches with a reusable synthesisable block. On start it walks the input space from 0 to 2^N-1 and holds each pattern for HOLD cycles. It samples the DUT output at the end of each hold, compares it against the golden truth table, and reports the mismatch count, the first failing pattern, and pass/fail.

Parameters:
N, 4, number of DUT inputs (legal range 1..8); stim[N-1] drives the MSB input (A in A,B,C,D ordering).
HOLD, 2, clock cycles each pattern is held (at least 1); the DUT output is sampled on the last cycle of the hold.
TRUTH, 16'hA5C3, golden truth table, width 2^N; bit k is the expected output for stim==k.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; honoured only in IDLE
abort  in  1  terminate sweep; honoured only in RUN
dut_out  in  1  output of DUT under test
stim  out  N  pattern driven to DUT inputs
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when a sweep completes
pass  out  1  high when the last completed sweep had zero mismatches
err_cnt  out  N+1  mismatch count of the current or last sweep
first_fail  out  N  lowest pattern index that mismatched
first_fail_valid  out  1  first_fail holds a valid index

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE.
  - stim, hold counter, err_cnt, first_fail all 0.
  - busy, done, pass, first_fail_valid all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - stim=0.
  - On start=1: clear err_cnt, first_fail, first_fail_valid and pass; stim=0; hold=0; go to RUN on the next edge.
- RUN:
  - busy=1.
  - hold increments each cycle.
  - When hold==HOLD-1, that edge is the sample edge: compare dut_out with TRUTH[stim].
  - On mismatch: err_cnt+1. If first_fail_valid==0, set first_fail=stim and first_fail_valid=1.
  - On the sample edge with stim<2^N-1: stim+1, hold=0.
  - On the sample edge with stim==2^N-1: go to DONE. stim is not incremented, so there is no wrap.
- DONE:
  - Lasts one cycle: done=1, busy=0, pass=(err_cnt==0).
  - Next edge goes to IDLE; stim returns to 0.
- Latency:
  - RUN lasts exactly 2^N*HOLD cycles.
  - done asserts on the cycle after the final sample edge.
  - Total from the start edge to the done cycle is 2^N*HOLD+1 cycles.
- Sampling assumes a combinational DUT: stim is registered, so with HOLD=1 dut_out has one full cycle to settle.
- err_cnt needs no saturation: the maximum 2^N fits in N+1 bits.
- start while in RUN or DONE is ignored. start and abort asserted together in IDLE: start wins.
- abort in RUN:
  - Next edge goes to IDLE with no done pulse and pass=0.
  - err_cnt, first_fail and first_fail_valid keep their partial values.
  - abort on the final sample edge wins over completion: no done.
- Outputs are registered. dut_out is the only combinational dependency, and it feeds only registers.

Test Plan:
1. Golden DUT model (dut_out=TRUTH[stim]), N=4, HOLD=2, start pulse:
   - stim steps 0..15, each value held 2 cycles.
   - done 33 cycles after the start edge.
   - err_cnt=0, pass=1, first_fail_valid=0.
2. Stuck-at-0 DUT (dut_out=0):
   - err_cnt=8 (popcount of 16'hA5C3), pass=0.
   - first_fail=0, first_fail_valid=1.
3. Inverted DUT (dut_out=~TRUTH[stim]):
   - err_cnt=16, first_fail=0, pass=0.
   - An immediate re-start clears all results before the new sweep.
4. Single-fault DUT, wrong only at stim=9:
   - err_cnt=1, first_fail=9.
   - start pulses during RUN have no effect and the sweep length is unchanged.
5. abort while stim=5:
   - IDLE next cycle, no done, pass=0, stim=0, err_cnt keeps its partial count.
   - rst_n pulsed low mid-run: all outputs 0 without waiting for a clock edge.
6. Instance with N=2, HOLD=1, TRUTH=4'b0110 (XOR) and a golden DUT:
   - done 5 cycles after the start edge, pass=1.

Source files
------------

// File: rtl/exhaustive_sweep_checker.sv
// rtl/exhaustive_sweep_checker.sv - exhaustive stimulus engine and truth-table checker
// Walks 0..2^N-1 on stim, samples dut_out at the end of each hold and scores it.
module exhaustive_sweep_checker #(
  parameter int                N     = 4,
  parameter int                HOLD  = 2,
  parameter logic [(1<<N)-1:0] TRUTH = 16'hA5C3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         dut_out,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_fail,
  output logic         first_fail_valid
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]  STIM_LAST = {N{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [HW-1:0] hold;
  logic          mismatch;
  logic [N:0]    err_next;

  assign mismatch = dut_out ^ TRUTH[stim];
  assign err_next = err_cnt + {{N{1'b0}}, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      stim             <= '0;
      hold             <= '0;
      err_cnt          <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          stim <= '0;
          hold <= '0;
          if (start) begin
            err_cnt          <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            busy             <= 1'b1;
            state            <= S_RUN;
          end
        end
        S_RUN: begin
          // abort outranks the sample edge, including the final one
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
            stim  <= '0;
            hold  <= '0;
          end else if (hold == HOLD_LAST) begin
            hold    <= '0;
            err_cnt <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail       <= stim;
              first_fail_valid <= 1'b1;
            end
            if (stim == STIM_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              stim <= stim + 1'b1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          stim  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// tb/tb_exhaustive_sweep_checker.sv - directed bench for exhaustive_sweep_checker
// Drives golden and faulty DUT models and checks results against hand-derived values.
module tb_exhaustive_sweep_checker;

  localparam logic [15:0] TRUTH_TB = 16'hA5C3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, dut_out;
  logic [3:0] stim;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail;
  logic       first_fail_valid;
  logic [1:0] mode;

  logic       start2, abort2, dut_out2;
  logic [1:0] stim2;
  logic       busy2, done2, pass2;
  logic [2:0] err_cnt2;
  logic [1:0] first_fail2;
  logic       first_fail_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0 golden, 1 stuck-at-0, 2 inverted, 3 wrong only at pattern 9
  always_comb begin
    dut_out = TRUTH_TB[stim];
    case (mode)
      2'd1: dut_out = 1'b0;
      2'd2: dut_out = ~TRUTH_TB[stim];
      2'd3: dut_out = TRUTH_TB[stim] ^ (stim == 4'd9);
      default: dut_out = TRUTH_TB[stim];
    endcase
  end

  assign dut_out2 = stim2[1] ^ stim2[0];

  exhaustive_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .stim(stim), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail(first_fail), .first_fail_valid(first_fail_valid)
  );

  exhaustive_sweep_checker #(.N(2), .HOLD(1), .TRUTH(4'b0110)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .dut_out(dut_out2),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .first_fail(first_fail2), .first_fail_valid(first_fail_valid2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a sweep on the N=4 instance; cyc counts cycles after the start edge, done cycle inclusive
  task automatic sweep(input bit start_mid, output int cyc, output int bad,
                       output logic [4:0] err0, output logic ffv0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc  = 1;
    bad  = 0;
    err0 = err_cnt;
    ffv0 = first_fail_valid;
    while (done !== 1'b1 && cyc < 200) begin
      if (stim !== 4'((cyc - 1) / 2) || busy !== 1'b1) bad++;
      start = start_mid && (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  int         cyc, bad, n;
  logic [4:0] err0;
  logic       ffv0;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    start2 = 1'b0; abort2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim", stim, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_ffv", first_fail_valid, 0);
    check("rst_ff", first_fail, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // golden sweep
    mode = 2'd0;
    sweep(1'b0, cyc, bad, err0, ffv0);
    check("gold_cycles", cyc, 33);
    check("gold_stim_steps", bad, 0);
    check("gold_done", done, 1);
    check("gold_busy", busy, 0);
    check("gold_err", err_cnt, 0);
    check("gold_pass", pass, 1);
    check("gold_ffv", first_fail_valid, 0);
    @(posedge clk); #1;
    check("gold_done_pulse", done, 0);
    check("gold_idle_stim", stim, 0);
    check("gold_pass_hold", pass, 1);

    // stuck-at-0
    mode = 2'd1;
    sweep(1'b0, cyc, bad, err0, ffv0);
    check("s0_cycles", cyc, 33);
    check("s0_err", err_cnt, 8);
    check("s0_pass", pass, 0);
    check("s0_ff", first_fail, 0);
    check("s0_ffv", first_fail_valid, 1);
    @(posedge clk); #1;

    // inverted
    mode = 2'd2;
    sweep(1'b0, cyc, bad, err0, ffv0);
    check("inv_err", err_cnt, 16);
    check("inv_ff", first_fail, 0);
    check("inv_pass", pass, 0);
    @(posedge clk); #1;

    // immediate restart with single fault, start pulsed mid-run
    mode = 2'd3;
    sweep(1'b1, cyc, bad, err0, ffv0);
    check("restart_err_clear", err0, 0);
    check("restart_ffv_clear", ffv0, 0);
    check("sf_cycles", cyc, 33);
    check("sf_stim_steps", bad, 0);
    check("sf_err", err_cnt, 1);
    check("sf_ff", first_fail, 9);
    check("sf_ffv", first_fail_valid, 1);
    check("sf_pass", pass, 0);
    @(posedge clk); #1;

    // abort at stim 5 with stuck-at-0 DUT: patterns 0 and 1 already mismatched
    mode = 2'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (stim !== 4'd5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach5", stim, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_stim", stim, 0);
    check("abort_err", err_cnt, 2);
    check("abort_ffv", first_fail_valid, 1);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    check("abort_stays_idle", n, 0);

    // asynchronous reset mid-run
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_stim", stim, 0);
    check("arst_err", err_cnt, 0);
    check("arst_ffv", first_fail_valid, 0);
    check("arst_ff", first_fail, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=2, HOLD=1 XOR instance
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 1;
    while (done2 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("xor_cycles", cyc, 5);
    check("xor_pass", pass2, 1);
    check("xor_err", err_cnt2, 0);
    check("xor_ffv", first_fail_valid2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
